// File: rtl/f2h_packet_arb.sv
// f2h_packet_arb: round-robin arbiter that frames producer packets as {0x80|id, len, payload} on one FX2 f2h channel.
// Optional build macro F2H_ARB_IDLE_FILL_EN: offer 0x00 filler bytes while idle so host reads never stall.
module f2h_packet_arb #(
  parameter int         NUM_PROD  = 4,
  parameter logic [6:0] CHAN_ADDR = 7'd0
) (
  input  logic                  fx2Clk_in,
  input  logic                  reset_in,
  input  logic [6:0]            chanAddr_in,
  output logic [7:0]            f2hData_out,
  output logic                  f2hValid_out,
  input  logic                  f2hReady_in,
  input  logic [8*NUM_PROD-1:0] prodData_in,
  input  logic [8*NUM_PROD-1:0] prodLen_in,
  input  logic [NUM_PROD-1:0]   prodValid_in,
  output logic [NUM_PROD-1:0]   prodReady_out,
  output logic                  grantValid_out,
  output logic [2:0]            grantId_out
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HDR_ID  = 2'd1;
  localparam logic [1:0] S_HDR_LEN = 2'd2;
  localparam logic [1:0] S_PAYLOAD = 2'd3;

  logic [1:0] state;
  logic [2:0] grant;
  logic [2:0] last_grant;
  logic [2:0] next_grant;
  logic [7:0] len;
  logic [7:0] count;
  logic       sel;
  logic       xfer;
  logic       found;
  logic [3:0] idx;

  // Producers padded to 8 slots so a 3-bit grant indexes without range issues.
  logic [7:0] prod_data [8];
  logic [7:0] prod_len  [8];
  logic [7:0] prod_vld;

  for (genvar i = 0; i < 8; i++) begin : g_slot
    if (i < NUM_PROD) begin : g_used
      assign prod_data[i] = prodData_in[8*i +: 8];
      assign prod_len[i]  = prodLen_in[8*i +: 8];
      assign prod_vld[i]  = prodValid_in[i];
    end else begin : g_pad
      assign prod_data[i] = 8'h00;
      assign prod_len[i]  = 8'h00;
      assign prod_vld[i]  = 1'b0;
    end
  end

  assign sel            = (chanAddr_in == CHAN_ADDR);
  assign xfer           = sel && f2hValid_out && f2hReady_in;
  assign grantValid_out = (state != S_IDLE);
  assign grantId_out    = grant;

  // Search starts one past the last winner so priority rotates only at packet boundaries.
  always_comb begin
    found      = 1'b0;
    next_grant = last_grant;
    idx        = 4'd0;
    for (int k = 1; k <= NUM_PROD; k++) begin
      idx = {1'b0, last_grant} + 4'(k);
      if (idx >= 4'(NUM_PROD)) idx = idx - 4'(NUM_PROD);
      if (!found && prod_vld[idx[2:0]]) begin
        found      = 1'b1;
        next_grant = idx[2:0];
      end
    end
  end

  always_comb begin
    f2hData_out   = 8'h00;
    f2hValid_out  = 1'b0;
    prodReady_out = '0;
    if (sel) begin
      case (state)
        S_IDLE: begin
`ifdef F2H_ARB_IDLE_FILL_EN
          f2hValid_out = !reset_in && !(|prodValid_in);
`endif
        end
        S_HDR_ID: begin
          f2hData_out  = {1'b1, 4'b0000, grant};
          f2hValid_out = 1'b1;
        end
        S_HDR_LEN: begin
          f2hData_out  = len;
          f2hValid_out = 1'b1;
        end
        default: begin
          f2hData_out  = prod_data[grant];
          f2hValid_out = prod_vld[grant];
          for (int i = 0; i < NUM_PROD; i++)
            prodReady_out[i] = f2hReady_in && (grant == 3'(i));
        end
      endcase
    end
  end

  always_ff @(posedge fx2Clk_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= S_IDLE;
      grant      <= 3'd0;
      last_grant <= 3'(NUM_PROD - 1);
      count      <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant <= next_grant;
            state <= S_HDR_ID;
          end
        end
        S_HDR_ID: begin
          if (xfer) state <= S_HDR_LEN;
        end
        S_HDR_LEN: begin
          if (xfer) begin
            count <= len;
            state <= S_PAYLOAD;
          end
        end
        default: begin
          if (xfer) begin
            if (count == 8'd0) begin
              state      <= S_IDLE;
              last_grant <= grant;
            end else begin
              count <= count - 8'd1;
            end
          end
        end
      endcase
    end
  end

  // Length is captured with the grant and needs no reset: it is only shown after a new grant.
  always_ff @(posedge fx2Clk_in) begin
    if (state == S_IDLE && found) len <= prod_len[next_grant];
  end

endmodule

// File: tb/tb_f2h_packet_arb.sv
// Bench for f2h_packet_arb: directed producer packets, scoreboard of expected host byte stream.
`timescale 1ns/1ps
module tb_f2h_packet_arb;
  localparam int         NP = 4;
  localparam logic [6:0] CH = 7'd0;

  logic            clk = 1'b0;
  logic            rst;
  logic [6:0]      chan;
  logic [7:0]      f2h_data;
  logic            f2h_valid;
  logic            f2h_ready;
  logic [8*NP-1:0] pdata;
  logic [8*NP-1:0] plen;
  logic [NP-1:0]   pvalid;
  logic [NP-1:0]   pready;
  logic            gvalid;
  logic [2:0]      gid;

  f2h_packet_arb #(.NUM_PROD(NP), .CHAN_ADDR(CH)) dut (
    .fx2Clk_in(clk), .reset_in(rst), .chanAddr_in(chan),
    .f2hData_out(f2h_data), .f2hValid_out(f2h_valid), .f2hReady_in(f2h_ready),
    .prodData_in(pdata), .prodLen_in(plen), .prodValid_in(pvalid),
    .prodReady_out(pready), .grantValid_out(gvalid), .grantId_out(gid)
  );

  always #5 clk = ~clk;

  logic [7:0]    pq [NP][$];
  logic [7:0]    plen_r [NP];
  logic [NP-1:0] stall;
  logic [NP-1:0] take;
  logic [7:0]    expq [$];
  int            xfer_cyc [$];
  int            vecs = 0;
  int            errs = 0;
  int            n_xfer = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_prod();
    for (int i = 0; i < NP; i++) begin
      pvalid[i]       = (pq[i].size() > 0) && !stall[i];
      pdata[8*i +: 8] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
      plen[8*i +: 8]  = plen_r[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int p, input logic [7:0] len, input logic [7:0] base);
    plen_r[p] = len;
    for (int j = 0; j <= int'(len); j++) pq[p].push_back(base + 8'(j));
    drive_prod();
  endtask

  task automatic expect_pkt(input int p, input logic [7:0] len, input logic [7:0] base);
    expq.push_back(8'h80 | 8'(p));
    expq.push_back(len);
    for (int j = 0; j <= int'(len); j++) expq.push_back(base + 8'(j));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((expq.size() != 0 || gvalid) && n < 300) begin
      tick();
      n++;
    end
    check(name, 32'(n < 300), 32'd1);
  endtask

  task automatic wait_xfer(input int target, input string name);
    int n = 0;
    while (n_xfer < target && n < 300) begin
      tick();
      n++;
    end
    check(name, 32'(n < 300), 32'd1);
  endtask

  // Producer model: pops a byte after each accepted handshake
  initial begin
    take = '0;
    forever begin
      @(negedge clk);
      take = pvalid & pready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++)
        if (take[i] && !rst) void'(pq[i].pop_front());
      drive_prod();
    end
  end

  // Monitor: every accepted host byte is popped from the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && chan == CH && f2h_valid && f2h_ready
`ifdef F2H_ARB_IDLE_FILL_EN
          && gvalid
`endif
         ) begin
        n_xfer++;
        xfer_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL stream_extra: got byte 0x%0h, expected no byte", f2h_data);
        end else begin
          check("stream_byte", 32'(f2h_data), 32'(expq.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst       = 1'b1;
    chan      = CH;
    f2h_ready = 1'b1;
    stall     = '0;
    for (int i = 0; i < NP; i++) plen_r[i] = 8'h00;
    drive_prod();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(f2h_valid), 32'd0);
    check("rst_data", 32'(f2h_data), 32'h00);
    check("rst_gvalid", 32'(gvalid), 32'd0);
    check("rst_gid", 32'(gid), 32'd0);
    check("rst_pready", 32'(pready), 32'd0);
    tick();
    rst = 1'b0;

    // Idle with host reading
    repeat (5) begin
      @(negedge clk);
`ifdef F2H_ARB_IDLE_FILL_EN
      check("idle_valid", 32'(f2h_valid), 32'd1);
`else
      check("idle_valid", 32'(f2h_valid), 32'd0);
`endif
      check("idle_data", 32'(f2h_data), 32'h00);
      tick();
    end

    // Producers 0,1,3 continuous, len 0: order 0,1,3,0 with one bubble before each header
    base = xfer_cyc.size();
    load(0, 8'h00, 8'hD0);
    load(0, 8'h00, 8'hD4);
    load(1, 8'h00, 8'hD1);
    load(3, 8'h00, 8'hD3);
    expect_pkt(0, 8'h00, 8'hD0);
    expect_pkt(1, 8'h00, 8'hD1);
    expect_pkt(3, 8'h00, 8'hD3);
    expect_pkt(0, 8'h00, 8'hD4);
    wait_drain("drain_rr");
    if (xfer_cyc.size() >= base + 12) begin
      check("rr_gap_01", 32'(xfer_cyc[base+3] - xfer_cyc[base]), 32'd4);
      check("rr_gap_13", 32'(xfer_cyc[base+6] - xfer_cyc[base+3]), 32'd4);
      check("rr_gap_30", 32'(xfer_cyc[base+9] - xfer_cyc[base+6]), 32'd4);
    end else begin
      check("rr_xfer_count", 32'(xfer_cyc.size() - base), 32'd12);
    end
    check("rr_gid", 32'(gid), 32'd0);

    // Producer 2 alone, len 3
    load(2, 8'h03, 8'hA0);
    expect_pkt(2, 8'h03, 8'hA0);
    wait_drain("drain_p2");
    check("p2_gid", 32'(gid), 32'd2);
    check("p2_gvalid", 32'(gvalid), 32'd0);

    // Producer 1 stalls 5 cycles after two payload bytes
    base = n_xfer;
    load(1, 8'h05, 8'hB0);
    expect_pkt(1, 8'h05, 8'hB0);
    wait_xfer(base + 4, "stall_reach");
    stall[1] = 1'b1;
    drive_prod();
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(f2h_valid), 32'd0);
      tick();
    end
    check("stall_no_xfer", 32'(n_xfer), 32'(base + 4));
    stall[1] = 1'b0;
    drive_prod();
    wait_drain("drain_stall");
    check("stall_total", 32'(n_xfer), 32'(base + 8));

    // Host deselects channel for 10 cycles while the length byte is pending
    base = n_xfer;
    load(0, 8'h01, 8'hC0);
    expect_pkt(0, 8'h01, 8'hC0);
    wait_xfer(base + 1, "desel_reach");
    chan = 7'd5;
    repeat (10) begin
      @(negedge clk);
      check("desel_valid", 32'(f2h_valid), 32'd0);
      check("desel_data", 32'(f2h_data), 32'h00);
      check("desel_pready", 32'(pready), 32'd0);
      tick();
    end
    check("desel_no_xfer", 32'(n_xfer), 32'(base + 1));
    chan = CH;
    @(negedge clk);
    check("resel_len", 32'(f2h_data), 32'h01);
    check("resel_valid", 32'(f2h_valid), 32'd1);
    wait_drain("drain_desel");

    // Reset mid-payload of producer 3; next grants go to 1 then 2
    base = n_xfer;
    load(3, 8'h07, 8'hE0);
    expect_pkt(3, 8'h07, 8'hE0);
    wait_xfer(base + 4, "rstp_reach");
    load(1, 8'h00, 8'hF1);
    load(2, 8'h00, 8'hF2);
    check("rstp_busy", 32'(gvalid), 32'd1);
    rst = 1'b1;
    #1;
    check("rstp_valid", 32'(f2h_valid), 32'd0);
    check("rstp_data", 32'(f2h_data), 32'h00);
    check("rstp_gvalid", 32'(gvalid), 32'd0);
    check("rstp_gid", 32'(gid), 32'd0);
    check("rstp_pready", 32'(pready), 32'd0);
    expq.delete();
    pq[3].delete();
    plen_r[3] = 8'h00;
    drive_prod();
    tick();
    tick();
    rst = 1'b0;
    expect_pkt(1, 8'h00, 8'hF1);
    expect_pkt(2, 8'h00, 8'hF2);
    wait_drain("drain_rstp");
    check("rstp_last_gid", 32'(gid), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/f2h_packet_arb.md
# f2h_packet_arb

Round-robin scheduler that shares one host-readable FPGA→host channel among NUM_PROD packet producers. It sits between producer logic and the f2h side of the FX2 comm interface (f2hData/f2hValid/f2hReady, chanAddr). Each granted packet is framed with a two-byte header (producer ID, length) so the host can demultiplex the byte stream.

## Interface
Parameters:
- NUM_PROD, 4: number of producers, 2..8.
- CHAN_ADDR, 7'd0: channel number served by this block.

Ports (one clock; reset is asynchronous and active-high):
- fx2Clk_in  input  1  48MHz system clock; all state on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- chanAddr_in  input  7  channel currently selected by the host.
- f2hData_out  output  8  byte offered to comm interface; 0x00 when not selected.
- f2hValid_out  output  1  byte on f2hData_out valid.
- f2hReady_in  input  1  comm interface consumes the byte at the next rising edge.
- prodData_in  input  8*NUM_PROD  producer data, producer i at [8i+7:8i].
- prodLen_in  input  8*NUM_PROD  packet payload length minus 1 (1..256 bytes); stable while prodValid_in[i] high and the packet is unfinished.
- prodValid_in  input  NUM_PROD  producer has a byte (request when idle).
- prodReady_out  output  NUM_PROD  producer byte consumed at the next rising edge.
- grantValid_out  output  1  a packet is in progress.
- grantId_out  output  3  ID of current/last granted producer.

## Operation
- sel = (chanAddr_in == CHAN_ADDR). Transfer = sel & f2hValid_out & f2hReady_in at a rising edge. When !sel: f2hValid_out=0, f2hData_out=0x00, prodReady_out=0, no state advances except arbitration in S_IDLE.
- States:
  - S_IDLE: if any prodValid_in, choose first requester after lastGrant (wrapping NUM_PROD-1→0); register grant, len=prodLen_in[grant]; → S_HDR_ID. f2hValid_out=0 (unless fill, see Configuration).
  - S_HDR_ID: f2hData_out={1'b1,4'b0000,grant}, f2hValid_out=1; on transfer → S_HDR_LEN.
  - S_HDR_LEN: f2hData_out=len, f2hValid_out=1; on transfer → S_PAYLOAD, count=len.
  - S_PAYLOAD: combinational pass-through: f2hData_out=prodData_in[grant], f2hValid_out=prodValid_in[grant], prodReady_out[grant]=sel & f2hReady_in; others 0. Each transfer decrements count (8-bit); transfer with count==0 → S_IDLE, lastGrant=grant.
- Producer deasserting valid mid-payload: f2hValid_out low, arbiter waits indefinitely; no timeout.
- Host deselecting channel mid-packet: state, count, grant held; resumes where stopped on reselect.
- grantValid_out=1 in S_HDR_ID, S_HDR_LEN, S_PAYLOAD.
- Reset (any time): state=S_IDLE, lastGrant=NUM_PROD-1 (producer 0 has first priority), count=0, grantId_out=0, grantValid_out=0, f2hValid_out=0, f2hData_out=0x00, prodReady_out=0. A partially sent packet is abandoned.

## Timing
- Request to first header byte offered: 1 cycle (S_IDLE registers grant).
- Packet of N payload bytes with host and producer always ready: N+3 cycles (1 arbitration bubble + 2 header + N).
- prodReady_out and f2hValid_out in S_PAYLOAD are same-cycle combinational from f2hReady_in/prodValid_in; header bytes and f2hData_out in header states are from registers only.
- Priority changes only at packet boundaries; no preemption.

## Configuration
- F2H_ARB_IDLE_FILL_EN defined: in S_IDLE with no request and sel, f2hValid_out=1, f2hData_out=0x00; a filler transfer does not change state. Host reads never stall; host discards 0x00 bytes (headers always have bit7=1).
- Undefined: f2hValid_out=0 in S_IDLE; host read stalls until a producer requests.

## Test plan
- Producer 2 alone, len=0x03, data 0xA0..0xA3, host always ready → stream 0x82,0x03,0xA0,0xA1,0xA2,0xA3; grantId_out=2; back to S_IDLE.
- Producers 0,1,3 request continuously, len=0 each → header IDs 0x80,0x81,0x83,0x80 in order; one bubble cycle before each header.
- Producer 1 drops valid for 5 cycles mid-payload → f2hValid_out low 5 cycles, no bytes lost or duplicated, count correct.
- chanAddr_in switched away for 10 cycles during S_HDR_LEN → outputs 0x00/valid 0; on return 0x length byte re-offered, packet completes.
- reset_in pulsed during payload of producer 3 → all outputs 0 immediately; next grant goes to lowest requesting ID.
- No requests, host reading: with F2H_ARB_IDLE_FILL_EN → 0x00 each cycle; without → f2hValid_out stays 0.
